// File: rtl/matrix_memory_2p.sv
// ---------------------------------------------------------------------------
// matrix_memory_2p
// Two-port (one write, one read) matrix element store addressed by
// (row, column). Reads are registered with a one-cycle valid strobe and can
// optionally address the transposed matrix. A clear request sweeps every
// entry to zero, one entry per cycle, while busy is high.
//
// Ports
//   clk          clock, all logic on rising edge
//   rst          synchronous reset, active low
//   clear        request a clear sweep (single-cycle pulse)
//   write        write enable
//   write_row    write row index
//   write_col    write column index
//   write_value  write data
//   read         read request
//   read_row     read row index
//   read_col     read column index
//   transpose    1: read element (read_col, read_row) of the stored matrix
//   data         registered read data
//   data_valid   data was loaded by a successful read at the last edge
//   busy         clear sweep in progress
//   addr_err     one-cycle pulse for an out-of-range access
//
// FSM states
//   state   | meaning
//   S_IDLE  | accepting reads/writes, waiting for clear
//   S_CLEAR | zeroing entry cnt_q each cycle, accesses ignored
// ---------------------------------------------------------------------------
module matrix_memory_2p #(
    parameter int ROW    = 2,
    parameter int COLUMN = 2,
    parameter int SIZE   = 8,
    parameter int ROW_W  = 1,
    parameter int COL_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             write,
    input  logic [ROW_W-1:0] write_row,
    input  logic [COL_W-1:0] write_col,
    input  logic [SIZE-1:0]  write_value,
    input  logic             read,
    input  logic [ROW_W-1:0] read_row,
    input  logic [COL_W-1:0] read_col,
    input  logic             transpose,
    output logic [SIZE-1:0]  data,
    output logic             data_valid,
    output logic             busy,
    output logic             addr_err
);

    localparam int N     = ROW * COLUMN;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Limits sized one bit wider than the index they bound, so a dimension
    // equal to 2**W still compares correctly.
    localparam logic [ROW_W:0] ROW_LIM_R = (ROW_W + 1)'(ROW);
    localparam logic [COL_W:0] COL_LIM_C = (COL_W + 1)'(COLUMN);
    localparam logic [COL_W:0] ROW_LIM_C = (COL_W + 1)'(ROW);
    localparam logic [ROW_W:0] COL_LIM_R = (ROW_W + 1)'(COLUMN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic [SIZE-1:0]  mem_q [N];
    logic [SIZE-1:0]  data_q;
    logic             data_valid_q;
    logic             busy_q;
    logic             addr_err_q;

    logic             accept;
    logic             wr_in;
    logic             rd_in;
    logic             wr_ok;
    logic             rd_ok;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [SIZE-1:0]  data_d;
    logic             addr_err_d;

    function automatic logic [IDX_W-1:0] lin_idx(input int unsigned r,
                                                  input int unsigned c);
        return IDX_W'(r * COLUMN + c);
    endfunction

    always_comb begin
        // A clear request in IDLE takes priority over any access that cycle.
        accept = (state_q == S_IDLE) && !clear;

        wr_in = ({1'b0, write_row} < ROW_LIM_R) && ({1'b0, write_col} < COL_LIM_C);
        if (transpose) begin
            rd_in = ({1'b0, read_col} < ROW_LIM_C) && ({1'b0, read_row} < COL_LIM_R);
        end else begin
            rd_in = ({1'b0, read_row} < ROW_LIM_R) && ({1'b0, read_col} < COL_LIM_C);
        end

        wr_ok = accept && write && wr_in;
        rd_ok = accept && read && rd_in;

        wr_idx = lin_idx(32'(write_row), 32'(write_col));
        if (transpose) begin
            rd_idx = lin_idx(32'(read_col), 32'(read_row));
        end else begin
            rd_idx = lin_idx(32'(read_row), 32'(read_col));
        end

        // Write-first bypass on a same-index collision.
        if (wr_ok && (wr_idx == rd_idx)) begin
            data_d = write_value;
        end else begin
            data_d = mem_q[rd_idx];
        end

        addr_err_d = accept && ((write && !wr_in) || (read && !rd_in));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    mem_q[cnt_q] <= '0;
                    cnt_q        <= cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (wr_ok) begin
                mem_q[wr_idx] <= write_value;
            end
            if (rd_ok) begin
                data_q <= data_d;
            end
            data_valid_q <= rd_ok;
            addr_err_q   <= addr_err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_matrix_memory_2p.sv
// Directed bench for matrix_memory_2p with a 2x3 matrix of bytes.
module tb_matrix_memory_2p;

    localparam int ROW    = 2;
    localparam int COLUMN = 3;
    localparam int SIZE   = 8;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             write;
    logic [ROW_W-1:0] write_row;
    logic [COL_W-1:0] write_col;
    logic [SIZE-1:0]  write_value;
    logic             read;
    logic [ROW_W-1:0] read_row;
    logic [COL_W-1:0] read_col;
    logic             transpose;
    logic [SIZE-1:0]  data;
    logic             data_valid;
    logic             busy;
    logic             addr_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] expm [6];

    matrix_memory_2p #(
        .ROW(ROW), .COLUMN(COLUMN), .SIZE(SIZE), .ROW_W(ROW_W), .COL_W(COL_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .write(write), .write_row(write_row), .write_col(write_col),
        .write_value(write_value),
        .read(read), .read_row(read_row), .read_col(read_col),
        .transpose(transpose),
        .data(data), .data_valid(data_valid), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int r, input int c, input logic [7:0] v);
        write       = 1'b1;
        write_row   = 2'(r);
        write_col   = 2'(c);
        write_value = v;
        step();
        write = 1'b0;
    endtask

    task automatic do_read(input int r, input int c, input logic t);
        read      = 1'b1;
        read_row  = 2'(r);
        read_col  = 2'(c);
        transpose = t;
        step();
        read      = 1'b0;
        transpose = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COLUMN; c++) begin
                do_read(r, c, 1'b0);
                chk(tag, 32'(data), 32'(expm[r*COLUMN+c]));
                chk({tag, "_valid"}, 32'(data_valid), 32'd1);
            end
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 6; i++) begin
            do_write(i / COLUMN, i % COLUMN, v);
            expm[i] = v;
        end
    endtask

    // Holds a write of (0,0)=01 and a read of (0,0) throughout the sweep;
    // both must be ignored. Returns the number of samples with busy high.
    task automatic count_busy(output int n);
        n = 0;
        write = 1'b1; write_row = 2'd0; write_col = 2'd0; write_value = 8'h01;
        read  = 1'b1; read_row  = 2'd0; read_col  = 2'd0; transpose   = 1'b0;
        while (busy && n < 20) begin
            n++;
            chk("busy_valid", 32'(data_valid), 32'd0);
            chk("busy_err", 32'(addr_err), 32'd0);
            step();
        end
        write = 1'b0;
        read  = 1'b0;
    endtask

    int nb;

    initial begin
        rst = 1'b0; clear = 1'b0; write = 1'b0; write_row = '0; write_col = '0;
        write_value = '0; read = 1'b0; read_row = '0; read_col = '0; transpose = 1'b0;
        for (int i = 0; i < 6; i++) expm[i] = 8'h00;

        step(); step();
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        rst = 1'b1;
        step();

        do_write(0, 0, 8'h11); expm[0] = 8'h11;
        do_write(0, 2, 8'h13); expm[2] = 8'h13;
        do_write(1, 1, 8'h22); expm[4] = 8'h22;
        chk("wr_no_err", 32'(addr_err), 32'd0);

        do_read(1, 1, 1'b0);
        chk("rd11_data", 32'(data), 32'h22);
        chk("rd11_valid", 32'(data_valid), 32'd1);
        step();
        chk("valid_pulse", 32'(data_valid), 32'd0);
        do_read(1, 0, 1'b0);
        chk("rd10_data", 32'(data), 32'h00);

        // Transposed: (row=2,col=0) reads stored (0,2).
        do_read(2, 0, 1'b1);
        chk("tr_data", 32'(data), 32'h13);
        chk("tr_valid", 32'(data_valid), 32'd1);
        // Transposed: (row=0,col=2) maps to stored row 2, out of range.
        do_read(0, 2, 1'b1);
        chk("tr_err", 32'(addr_err), 32'd1);
        chk("tr_err_data", 32'(data), 32'h13);
        chk("tr_err_valid", 32'(data_valid), 32'd0);
        step();
        chk("err_pulse", 32'(addr_err), 32'd0);

        // Write-first collision.
        write = 1'b1; write_row = 2'd1; write_col = 2'd2; write_value = 8'hA5;
        read  = 1'b1; read_row  = 2'd1; read_col  = 2'd2;
        step();
        write = 1'b0; read = 1'b0;
        expm[5] = 8'hA5;
        chk("bypass_data", 32'(data), 32'hA5);
        chk("bypass_valid", 32'(data_valid), 32'd1);

        do_write(2, 0, 8'h77);
        chk("wr_oob_err", 32'(addr_err), 32'd1);
        do_write(0, 3, 8'h78);
        chk("wr_oob_col_err", 32'(addr_err), 32'd1);
        read_all("after_oob");

        // Full clear sweep.
        fill(8'hFF);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_busy_rise", 32'(busy), 32'd1);
        count_busy(nb);
        chk("clr_busy_len", 32'(nb), 32'd6);
        for (int i = 0; i < 6; i++) expm[i] = 8'h00;
        read_all("after_clr");

        // Reset in the middle of a sweep.
        fill(8'hFF);
        do_read(0, 1, 1'b0);
        chk("pre_rst_data", 32'(data), 32'hFF);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(data), 32'h00);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        for (int i = 0; i < 6; i++) expm[i] = 8'h00;
        read_all("after_midrst");

        // Re-issued clear after the aborted one.
        do_write(1, 1, 8'h22);
        clear = 1'b1;
        step();
        clear = 1'b0;
        count_busy(nb);
        chk("reclr_busy_len", 32'(nb), 32'd6);
        do_read(1, 1, 1'b0);
        chk("reclr_data", 32'(data), 32'h00);

        // Data holds with read idle.
        do_write(1, 1, 8'h22);
        do_read(1, 1, 1'b0);
        chk("hold_first", 32'(data), 32'h22);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_data", 32'(data), 32'h22);
            chk("hold_valid", 32'(data_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
